bits_timing_tracker: RTL and testbench
======================================

// Module: bits_timing_tracker
// PURPOSE
//  Symbol-timing recovery and bit decision stage of the RFID backscatter receive chain. It sits after
//  the bits correlator bank and consumes one vector of NSYM correlation scores per corr_vld. It uses
//  early/on-time/late gating with a loop-filtered period adjuster, a per-symbol bit map, lock detection
//  and a runtime-loadable nominal period, so FM0 and Miller modes share one block.
// PARAMETERS
//  NSYM           4        candidate symbols per bit (>=2)
//  CORR_WIDTH     3        unsigned width of each correlation score
//  PERIOD_WIDTH   6        width of period, count and cfg_period
//  PERIOD_DEFAULT 4        period loaded at reset (samples per bit)
//  GATE           1        early/late gate offset and period step, in samples
//  MAX_DEV        2        max |period - nominal|; clamps adjustment
//  LOOP_THRESH    2        loop accumulator magnitude that triggers a period step
//  LOCK_COUNT     8        consecutive zero-error bits required to assert locked
//  SYM_BIT_MAP    4'b1001  bit i = out_dat value decoded for symbol i
// PORTS
//  clk        in   1                 clock
//  rst        in   1                 reset: synchronous, active-high
//  cfg_period in   PERIOD_WIDTH      nominal period; sampled on cfg_load
//  cfg_load   in   1                 reload nominal period and restart timing
//  corr_dat   in   NSYM*CORR_WIDTH   scores; symbol i at [i*CORR_WIDTH +: CORR_WIDTH]
//  corr_vld   in   1                 corr_dat valid this cycle
//  out_dat    out  1                 decided bit
//  out_vld    out  1                 one-cycle pulse per decided bit
//  out_sym    out  $clog2(NSYM)      decided symbol index
//  locked     out  1                 timing loop locked
//  period     out  PERIOD_WIDTH      current tracked period
// BEHAVIOUR
//  - Reset: count=0, period=nominal=PERIOD_DEFAULT, acc=0, lock_cnt=0, all sample regs=0;
//    out_vld=0, out_dat=SYM_BIT_MAP[0], out_sym=0, locked=0.
//  - Priority: rst > cfg_load > normal operation. cfg_load sets nominal=period=cfg_period and
//    clears count, acc and lock_cnt. A corr_vld in the same cycle as cfg_load is discarded.
//  - count advances only on corr_vld and wraps to 0 when count >= period-1. The >= comparison keeps
//    the count safe after the period shrinks.
//  - Strobes, qualified by corr_vld:
//      late   at count == GATE-1
//      early  at count == period-GATE-1
//      ontime at count == period-1
//    Each strobe captures corr_dat into its own register.
//  - Decision, with ontime strobe at cycle T:
//      T+1: out_sym <= argmax of ontime scores; ties go to the lowest index.
//      T+2: out_vld=1 for one cycle; out_dat = SYM_BIT_MAP[out_sym].
//  - Error, one cycle after the late strobe, using the scores of out_sym:
//      +1 if late > ontime and late >= early
//      -1 if early > ontime and early > late
//       0 otherwise
//  - Loop: acc (signed) += err. When acc reaches +LOOP_THRESH, period += GATE; when it reaches
//    -LOOP_THRESH, period -= GATE; acc clears to 0 on either step. period saturates at
//    nominal +/- MAX_DEV; at the limit the step is dropped and acc still clears.
//  - Lock: lock_cnt increments (saturating) on each err==0 evaluation and clears on err!=0 or on a
//    period step. locked = (lock_cnt >= LOCK_COUNT).
//  - Caller guarantees cfg_period - MAX_DEV >= 2*GATE+2; otherwise behaviour is undefined.
//  - All arithmetic is unsigned on period and count. acc is $clog2(LOOP_THRESH)+2 bits, signed.
// CONFIGURATION
//  BITS_TRACKER_SOFT_EN defined: adds output port out_margin [CORR_WIDTH]. It equals the winning
//    ontime score minus the runner-up score, registered alongside out_sym and valid with out_vld.
//    A tie gives 0.
//  Not defined: the port is absent and no second-max logic is built.
// STRUCTURE
//  - Package bits_pkg: ERR_* encodings, the ONTIME/LATE/ERLY sample selectors, and the
//    clog2-derived width constants shared with the correlator bank.
//  - One sub-module, bits_argmax: combinational argmax over NSYM scores with lowest-index tie-break.
//    It also returns the runner-up score when BITS_TRACKER_SOFT_EN is defined.
//  - The counter, strobes, loop filter and lock logic stay in this module.
// TESTING
//  1. Reset, then no corr_vld for 20 cycles -> out_vld stays 0, period==4, locked==0.
//  2. Ideal symbol 3 every bit, period 4, 10 bits -> 10 out_vld pulses 2 cycles after each ontime
//     strobe; out_dat=1, out_sym=3; locked rises after the 8th zero-error bit.
//  3. Source period 5, nominal 4 -> late wins; after 2 errors period==5; acc cleared; lock_cnt cleared.
//  4. Source period 8, nominal 4, MAX_DEV 2 -> period saturates at 6, never 7; no count overrun.
//  5. cfg_load=1 with cfg_period=8 and coincident corr_vld mid-bit -> next cycle period==8, count==0,
//     locked==0; that sample is ignored.
//  6. Ontime scores {2,5,5,1} -> out_sym==1 (tie to lower index), out_dat==0.
//     With BITS_TRACKER_SOFT_EN defined, out_margin==0.

Source files
------------

// File: rtl/bits_timing_tracker_pkg.sv
// Shared encodings and width helpers for the bits receive chain (package bits_pkg).
package bits_pkg;

    typedef enum logic [1:0] {
        ERR_ZERO  = 2'b00,
        ERR_PLUS  = 2'b01,
        ERR_MINUS = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        ONTIME = 2'd0,
        LATE   = 2'd1,
        ERLY   = 2'd2
    } sample_sel_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned NSYM_DEFAULT       = 4;
    localparam int unsigned CORR_WIDTH_DEFAULT = 3;
    localparam int unsigned SYM_IDX_W          = idx_width(NSYM_DEFAULT);
    localparam int unsigned CORR_BUS_W         = NSYM_DEFAULT * CORR_WIDTH_DEFAULT;

endpackage

// File: rtl/bits_timing_tracker_argmax.sv
// Combinational argmax over NSYM scores, lowest index wins ties.
// With BITS_TRACKER_SOFT_EN the best and runner-up scores are also returned.
module bits_argmax
    import bits_pkg::*;
#(
    parameter int unsigned NSYM       = 4,
    parameter int unsigned CORR_WIDTH = 3
) (
    input  logic [NSYM*CORR_WIDTH-1:0] scores,
    output logic [$clog2(NSYM)-1:0]    idx
`ifdef BITS_TRACKER_SOFT_EN
    ,
    output logic [CORR_WIDTH-1:0]      best_val,
    output logic [CORR_WIDTH-1:0]      second_val
`endif
);

    logic [CORR_WIDTH-1:0] best;
    logic [CORR_WIDTH-1:0] second;
    logic [CORR_WIDTH-1:0] s;

    // A score equal to the current best only updates the runner-up, so ties give zero margin.
    always_comb begin
        best   = scores[CORR_WIDTH-1:0];
        second = '0;
        idx    = '0;
        s      = '0;
        for (int unsigned i = 1; i < NSYM; i++) begin
            s = scores[i*CORR_WIDTH +: CORR_WIDTH];
            if (s > best) begin
                second = best;
                best   = s;
                idx    = ($clog2(NSYM))'(i);
            end else if (s > second) begin
                second = s;
            end
        end
    end

`ifdef BITS_TRACKER_SOFT_EN
    assign best_val   = best;
    assign second_val = second;
`endif

endmodule

// File: rtl/bits_timing_tracker.sv
// Symbol-timing recovery and bit decision: early/on-time/late gating, loop-filtered period, lock detect.
// Optional macro BITS_TRACKER_SOFT_EN adds the out_margin soft-decision port.
module bits_timing_tracker
    import bits_pkg::*;
#(
    parameter int unsigned   NSYM           = 4,
    parameter int unsigned   CORR_WIDTH     = 3,
    parameter int unsigned   PERIOD_WIDTH   = 6,
    parameter int unsigned   PERIOD_DEFAULT = 4,
    parameter int unsigned   GATE           = 1,
    parameter int unsigned   MAX_DEV        = 2,
    parameter int unsigned   LOOP_THRESH    = 2,
    parameter int unsigned   LOCK_COUNT     = 8,
    parameter logic [NSYM-1:0] SYM_BIT_MAP  = 4'b1001
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PERIOD_WIDTH-1:0]    cfg_period,
    input  logic                       cfg_load,
    input  logic [NSYM*CORR_WIDTH-1:0] corr_dat,
    input  logic                       corr_vld,
    output logic                       out_dat,
    output logic                       out_vld,
    output logic [$clog2(NSYM)-1:0]    out_sym,
    output logic                       locked,
    output logic [PERIOD_WIDTH-1:0]    period
`ifdef BITS_TRACKER_SOFT_EN
    ,
    output logic [CORR_WIDTH-1:0]      out_margin
`endif
);

    localparam int unsigned PW     = PERIOD_WIDTH;
    localparam int unsigned CW     = CORR_WIDTH;
    localparam int unsigned SYM_W  = $clog2(NSYM);
    localparam int unsigned ACC_W  = $clog2(LOOP_THRESH) + 2;
    localparam int unsigned LOCK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [PW-1:0]           GATE_P  = PW'(GATE);
    localparam logic [PW-1:0]           LATE_AT = PW'(GATE - 1);
    localparam logic [PW-1:0]           DEV_P   = PW'(MAX_DEV);
    localparam logic signed [ACC_W-1:0] THR_P   = ACC_W'(LOOP_THRESH);
    localparam logic signed [ACC_W-1:0] THR_N   = -THR_P;

    logic [PW-1:0]          count;
    logic [PW-1:0]          nominal;
    logic [NSYM*CW-1:0]     samp [3];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] err_val;
    logic signed [ACC_W-1:0] acc_sum;
    logic [LOCK_W-1:0]      lock_cnt;
    logic                   dec_pend;
    logic                   vld_pend;
    logic                   err_pend;
    logic                   st_late;
    logic                   st_early;
    logic                   st_on;
    logic                   up_ok;
    logic                   dn_ok;
    logic [SYM_W-1:0]       win_idx;
    err_e                   err;

    function automatic logic [CW-1:0] score_of(input logic [NSYM*CW-1:0] v,
                                               input logic [SYM_W-1:0] i);
        return v[i*CW +: CW];
    endfunction

    assign st_late  = corr_vld && (count == LATE_AT);
    assign st_early = corr_vld && (count == period - GATE_P - PW'(1));
    assign st_on    = corr_vld && (count == period - PW'(1));

`ifdef BITS_TRACKER_SOFT_EN
    logic [CW-1:0] win_best;
    logic [CW-1:0] win_second;

    bits_argmax #(.NSYM(NSYM), .CORR_WIDTH(CW)) u_argmax (
        .scores     (samp[ONTIME]),
        .idx        (win_idx),
        .best_val   (win_best),
        .second_val (win_second)
    );
`else
    bits_argmax #(.NSYM(NSYM), .CORR_WIDTH(CW)) u_argmax (
        .scores (samp[ONTIME]),
        .idx    (win_idx)
    );
`endif

    always_comb begin
        logic [CW-1:0] s_on;
        logic [CW-1:0] s_late;
        logic [CW-1:0] s_early;
        s_on    = score_of(samp[ONTIME], out_sym);
        s_late  = score_of(samp[LATE], out_sym);
        s_early = score_of(samp[ERLY], out_sym);
        err     = ERR_ZERO;
        err_val = '0;
        if (s_late > s_on && s_late >= s_early) begin
            err     = ERR_PLUS;
            err_val = ACC_W'(1);
        end else if (s_early > s_on && s_early > s_late) begin
            err     = ERR_MINUS;
            err_val = '1;
        end
    end

    assign acc_sum = acc + err_val;
    assign up_ok   = ({1'b0, period} + {1'b0, GATE_P}) <= ({1'b0, nominal} + {1'b0, DEV_P});
    assign dn_ok   = (period - GATE_P) >= (nominal - DEV_P);
    assign locked  = (lock_cnt >= LOCK_W'(LOCK_COUNT));

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            period   <= PW'(PERIOD_DEFAULT);
            nominal  <= PW'(PERIOD_DEFAULT);
            acc      <= '0;
            lock_cnt <= '0;
            for (int unsigned i = 0; i < 3; i++) samp[i] <= '0;
            dec_pend <= 1'b0;
            vld_pend <= 1'b0;
            err_pend <= 1'b0;
            out_vld  <= 1'b0;
            out_dat  <= SYM_BIT_MAP[0];
            out_sym  <= '0;
`ifdef BITS_TRACKER_SOFT_EN
            out_margin <= '0;
`endif
        end else begin
            // Decision pipeline finishes bits already strobed, even across a reload.
            dec_pend <= 1'b0;
            err_pend <= 1'b0;
            vld_pend <= dec_pend;
            out_vld  <= vld_pend;
            if (dec_pend) begin
                out_sym <= win_idx;
`ifdef BITS_TRACKER_SOFT_EN
                out_margin <= win_best - win_second;
`endif
            end
            if (vld_pend) out_dat <= SYM_BIT_MAP[out_sym];

            if (cfg_load) begin
                nominal  <= cfg_period;
                period   <= cfg_period;
                count    <= '0;
                acc      <= '0;
                lock_cnt <= '0;
            end else begin
                if (corr_vld) begin
                    count <= (count >= period - PW'(1)) ? '0 : count + PW'(1);
                    if (st_late)  samp[LATE]   <= corr_dat;
                    if (st_early) samp[ERLY]   <= corr_dat;
                    if (st_on)    samp[ONTIME] <= corr_dat;
                    dec_pend <= st_on;
                    err_pend <= st_late;
                end
                if (err_pend) begin
                    if (acc_sum >= THR_P) begin
                        if (up_ok) period <= period + GATE_P;
                        acc      <= '0;
                        lock_cnt <= '0;
                    end else if (acc_sum <= THR_N) begin
                        if (dn_ok) period <= period - GATE_P;
                        acc      <= '0;
                        lock_cnt <= '0;
                    end else begin
                        acc <= acc_sum;
                        if (err == ERR_ZERO) begin
                            if (lock_cnt != '1) lock_cnt <= lock_cnt + LOCK_W'(1);
                        end else begin
                            lock_cnt <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bits_timing_tracker.sv
// Directed self-checking bench for bits_timing_tracker (default parameters).
module tb_bits_timing_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  cfg_period;
    logic        cfg_load;
    logic [11:0] corr_dat;
    logic        corr_vld;
    logic        out_dat;
    logic        out_vld;
    logic [1:0]  out_sym;
    logic        locked;
    logic [5:0]  period;
`ifdef BITS_TRACKER_SOFT_EN
    logic [2:0]  out_margin;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bits_timing_tracker dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_period (cfg_period),
        .cfg_load   (cfg_load),
        .corr_dat   (corr_dat),
        .corr_vld   (corr_vld),
        .out_dat    (out_dat),
        .out_vld    (out_vld),
        .out_sym    (out_sym),
        .locked     (locked),
        .period     (period)
`ifdef BITS_TRACKER_SOFT_EN
        ,
        .out_margin (out_margin)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic v, input logic [11:0] d);
        corr_vld = v;
        corr_dat = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] mk(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
        return {d[2:0], c[2:0], b[2:0], a[2:0]};
    endfunction

    initial begin
        int c;
        int pb;
        int pulses;
        logic [2:0] on_hist;
        logic       on_now;
        logic [11:0] d;

        rst = 1'b1; cfg_load = 1'b0; cfg_period = '0; corr_vld = 1'b0; corr_dat = '0;
        step(1'b0, '0);
        step(1'b0, '0);
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_out_dat", 32'(out_dat), 1);
        chk("rst_out_sym", 32'(out_sym), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_period", 32'(period), 4);
        rst = 1'b0;

        // Idle: no corr_vld for 20 cycles.
        for (int k = 0; k < 20; k++) begin
            step(1'b0, '0);
            chk("idle_out_vld", 32'(out_vld), 0);
        end
        chk("idle_period", 32'(period), 4);
        chk("idle_locked", 32'(locked), 0);

        // Ideal symbol 3 peaking at the on-time sample, period 4.
        pulses = 0;
        for (int k = 0; k < 42; k++) begin
            d = (k % 4 == 3) ? mk(0, 0, 0, 7) : mk(0, 0, 0, 2);
            step(1'b1, d);
            chk("ideal_out_vld", 32'(out_vld), (k % 4 == 1 && k >= 5) ? 1 : 0);
            if (out_vld) pulses++;
            if (k % 4 == 1 && k >= 5) begin
                chk("ideal_out_dat", 32'(out_dat), 1);
                chk("ideal_out_sym", 32'(out_sym), 3);
`ifdef BITS_TRACKER_SOFT_EN
                chk("ideal_margin", 32'(out_margin), 7);
`endif
            end
            chk("ideal_locked", 32'(locked), (k >= 29) ? 1 : 0);
            chk("ideal_period", 32'(period), 4);
        end
        chk("ideal_pulses", 32'(pulses), 10);

        // Late sample always wins: period steps 4->5->6 and saturates at 6.
        rst = 1'b1;
        step(1'b0, '0);
        rst = 1'b0;
        chk("slow_rst_period", 32'(period), 4);
        c = 0;
        on_hist = '0;
        for (int k = 0; k < 44; k++) begin
            pb = (k <= 9) ? 4 : (k <= 19) ? 5 : 6;
            if (c == 0)           d = mk(0, 0, 0, 6);
            else if (c == pb - 2) d = mk(0, 0, 0, 1);
            else if (c == pb - 1) d = mk(0, 0, 0, 4);
            else                  d = '0;
            on_now = (c == pb - 1);
            step(1'b1, d);
            on_hist = {on_hist[1:0], on_now};
            chk("slow_period", 32'(period), (k < 9) ? 4 : (k < 19) ? 5 : 6);
            chk("slow_out_vld", 32'(out_vld), 32'(on_hist[2]));
            chk("slow_locked", 32'(locked), 0);
            c = (c >= pb - 1) ? 0 : c + 1;
        end

        // Reload mid-bit with a coincident sample that must be ignored.
        cfg_load = 1'b1;
        cfg_period = 6'd8;
        step(1'b1, mk(7, 7, 7, 7));
        cfg_load = 1'b0;
        chk("load_period", 32'(period), 8);
        chk("load_locked", 32'(locked), 0);
        chk("load_out_vld", 32'(out_vld), 0);
        for (int j = 0; j < 19; j++) begin
            if (j % 8 == 7)      d = (j < 8) ? mk(0, 0, 0, 7) : mk(2, 5, 5, 1);
            else if (j % 8 == 6) d = mk(0, 0, 0, 1);
            else                 d = '0;
            step(1'b1, d);
            chk("load_vld", 32'(out_vld), (j == 9 || j == 17) ? 1 : 0);
            if (j == 9) begin
                chk("load_sym", 32'(out_sym), 3);
                chk("load_dat", 32'(out_dat), 1);
`ifdef BITS_TRACKER_SOFT_EN
                chk("load_margin", 32'(out_margin), 7);
`endif
            end
            if (j == 17) begin
                chk("tie_sym", 32'(out_sym), 1);
                chk("tie_dat", 32'(out_dat), 0);
`ifdef BITS_TRACKER_SOFT_EN
                chk("tie_margin", 32'(out_margin), 0);
`endif
            end
            chk("load_hold_period", 32'(period), 8);
        end
        chk("load_end_locked", 32'(locked), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
